// File: rtl/side_buf_ctrl.sv
// MinBD side buffer: storage FIFO with redirect/deflect write arbitration, inject-stage pop,
// and full/empty/starve flags. Optional `SIDE_BUF_STATS_EN adds hwm and starve_events outputs.
module side_buf_ctrl #(
   parameter int DATA_W        = 64,
   parameter int DEPTH         = 4,
   parameter int STARVE_THRESH = 2,
   parameter int STARVE_W      = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [DATA_W-1:0]     din_redirect,
   input  logic                  redirect_gnt,
   input  logic [DATA_W-1:0]     din_eject,
   input  logic                  deflect_to_side_buf_vld,
   input  logic                  inject_gnt,
   output logic [DATA_W-1:0]     dout_inject,
   output logic                  starve,
   output logic                  full,
   output logic                  empty,
   output logic                  wr_collide,
   output logic                  overflow
`ifdef SIDE_BUF_STATS_EN
   ,
   output logic [$clog2(DEPTH):0] hwm,
   output logic [15:0]            starve_events
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_next;
   logic [STARVE_W-1:0] starve_cnt;
   logic [STARVE_W-1:0] starve_cnt_next;

   logic              wr_req;
   logic              do_wr;
   logic              do_rd;
   logic [DATA_W-1:0] wr_data;

   // Flags come only from registered state so nothing downstream sees an input-to-flag path.
   assign full        = (count == CNT_W'(DEPTH));
   assign empty       = (count == '0);
   assign starve      = (starve_cnt >= STARVE_W'(STARVE_THRESH));
   assign dout_inject = mem[rd_ptr];

   assign wr_req  = redirect_gnt | deflect_to_side_buf_vld;
   assign wr_data = redirect_gnt ? din_redirect : din_eject;
   assign do_wr   = wr_req & ~full;
   assign do_rd   = inject_gnt & ~empty;

   always_comb begin
      count_next = count;
      case ({do_wr, do_rd})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   always_comb begin
      starve_cnt_next = starve_cnt;
      if (empty || inject_gnt)
         starve_cnt_next = '0;
      else if (starve_cnt != '1)
         starve_cnt_next = starve_cnt + STARVE_W'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         wr_collide <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count      <= count_next;
         starve_cnt <= starve_cnt_next;
         wr_collide <= wr_collide | (redirect_gnt & deflect_to_side_buf_vld);
         overflow   <= overflow | (wr_req & full);
      end
   end

`ifdef SIDE_BUF_STATS_EN
   logic starve_next;
   assign starve_next = (starve_cnt_next >= STARVE_W'(STARVE_THRESH));

   // hwm tracks the next count so it agrees with count on the same cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hwm           <= '0;
         starve_events <= '0;
      end else begin
         if (count_next > hwm) hwm <= count_next;
         if (starve_next && !starve && starve_events != 16'hFFFF)
            starve_events <= starve_events + 16'd1;
      end
   end
`endif

endmodule
